// File: rtl/stream_demux.sv
// Registered 1-to-7 valid/ready stream demultiplexer; code 7 discards the word.
// Optional saturating discard counter enabled by STREAM_DEMUX_DROP_CNT_EN.
module stream_demux #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7*WIDTH-1:0] out_data,
  output logic [6:0]         out_valid,
  input  logic [6:0]         out_ready
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  logic [WIDTH-1:0] data_q [7];
  logic [6:0]       valid_q;
  logic             accept;

  // A channel can take a word when it is empty or is draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (in_sel == 3'd7) begin
        in_ready = 1'b1;
      end else begin
        for (int k = 0; k < 7; k++) begin
          if (in_sel == 3'(k)) begin
            in_ready = !valid_q[k] || out_ready[k];
          end
        end
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 7; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (accept && in_sel == 3'(k)) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] && out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 7; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid = valid_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (accept && in_sel == 3'd7 && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vector table, hand sequences
// and a randomized run against a per-channel occupancy model.
module tb_stream_demux;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic [2:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [7*W-1:0] out_data;
  logic [6:0]     out_valid;
  logic [6:0]     out_ready;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0]    drop_count;
`endif

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  // Reference model: what each channel holds, and how many words were dropped.
  logic [W-1:0] m_data [7];
  logic [6:0]   m_valid = '0;
  int           m_drops = 0;
  bit           stalled = 1'b0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit         r;
    bit         v;
    logic [2:0] s;
    logic [15:0] d;
    logic [6:0] o;
    bit         er;
    logic [6:0] ev;
    int         ch;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want)
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    else
      passed++;
  endtask

  function automatic logic expReady();
    if (rst) return 1'b0;
    if (in_sel == 3'd7) return 1'b1;
    return !m_valid[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [7*W-1:0] modelData();
    logic [7*W-1:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r[k*W +: W] = m_data[k];
    return r;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input logic [2:0] s,
                               input logic [W-1:0] d, input logic [6:0] o);
    rst       = r;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = o;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, " in_ready"}, in_ready, expReady());
    chk({tag, " out_valid"}, out_valid, m_valid);
    chk({tag, " out_data"}, out_data, modelData());
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk({tag, " drop_count"}, drop_count, m_drops);
`endif
  endtask

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic tick();
    bit acc;
    acc     = in_valid && expReady();
    stalled = in_valid && !expReady();
    @(posedge clk);
    if (rst) begin
      m_valid = '0;
      m_drops = 0;
      for (int k = 0; k < 7; k++) m_data[k] = '0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (acc && in_sel == 3'(k)) begin
          m_data[k]  = in_data;
          m_valid[k] = 1'b1;
        end else if (m_valid[k] && out_ready[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      if (acc && in_sel == 3'd7 && m_drops < 65535) m_drops++;
    end
    #1;
  endtask

  task automatic cycle(input string tag, input bit r, input bit v, input logic [2:0] s,
                       input logic [W-1:0] d, input logic [6:0] o);
    applyStimulus(r, v, s, d, o);
    #3;
    checkOutput(tag);
    tick();
  endtask

  initial begin
    logic [2:0]   rs;
    logic [W-1:0] rd;
    bit           rv;

    for (int k = 0; k < 7; k++) m_data[k] = '0;

    // Reset pair, routing sweep, then backpressure on channel 3 with a word to 5.
    tbl[0]  = '{1'b1, 1'b1, 3'd0, 16'h1234, 7'h7F, 1'b0, 7'h00, 0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 3'd0, 16'h1234, 7'h7F, 1'b0, 7'h00, 0, 16'h0000};
    for (int k = 0; k < 7; k++)
      tbl[2+k] = '{1'b0, 1'b1, 3'(k), 16'h1000 + 16'(k), 7'h7F, 1'b1,
                   (k == 0) ? 7'h00 : 7'(1 << (k-1)), (k == 0) ? 0 : k-1,
                   (k == 0) ? 16'h0000 : 16'h1000 + 16'(k-1)};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F, 1'b1, 7'h40, 6, 16'h1006};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F, 1'b1, 7'h00, 6, 16'h1006};
    tbl[11] = '{1'b0, 1'b1, 3'd3, 16'hAAAA, 7'h77, 1'b1, 7'h00, 3, 16'h1003};
    tbl[12] = '{1'b0, 1'b1, 3'd5, 16'h5555, 7'h77, 1'b1, 7'h08, 3, 16'hAAAA};
    tbl[13] = '{1'b0, 1'b1, 3'd3, 16'hBBBB, 7'h77, 1'b0, 7'h28, 5, 16'h5555};
    tbl[14] = '{1'b0, 1'b1, 3'd3, 16'hBBBB, 7'h77, 1'b0, 7'h08, 3, 16'hAAAA};
    tbl[15] = '{1'b0, 1'b1, 3'd3, 16'hBBBB, 7'h7F, 1'b1, 7'h08, 3, 16'hAAAA};
    tbl[16] = '{1'b0, 1'b0, 3'd0, 16'h0000, 7'h77, 1'b1, 7'h08, 3, 16'hBBBB};
    tbl[17] = '{1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F, 1'b1, 7'h08, 3, 16'hBBBB};
    tbl[18] = '{1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F, 1'b1, 7'h00, 3, 16'hBBBB};

    applyStimulus(1'b1, 1'b1, 3'd0, 16'h1234, 7'h7F);
    tick();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].o);
      #3;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].er);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d data ch%0d", i, tbl[i].ch), out_data[tbl[i].ch*W +: W], tbl[i].ed);
      if (i < 2) chk($sformatf("vec%0d all data zero", i), out_data, '0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      if (i < 2) chk($sformatf("vec%0d drop_count", i), drop_count, 0);
`endif
      tick();
    end

    // Discards never stall and never touch a held channel.
    cycle("load ch1", 1'b0, 1'b1, 3'd1, 16'h0111, 7'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd7, 16'd42, 7'h00);
      #3;
      chk($sformatf("discard%0d in_ready", i), in_ready, 1'b1);
      chk($sformatf("discard%0d out_valid", i), out_valid, 7'h02);
      checkOutput($sformatf("discard%0d", i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 7'h00);
    #3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("drop_count after 10", drop_count, 16'd10);
`endif
    chk("ch1 held after discards", out_data[1*W +: W], 16'h0111);
    tick();

    // Reset while channels 0, 1, 2 and 6 hold words.
    cycle("mid load0", 1'b0, 1'b1, 3'd0, 16'hC000, 7'h00);
    cycle("mid load2", 1'b0, 1'b1, 3'd2, 16'hC002, 7'h00);
    cycle("mid load6", 1'b0, 1'b1, 3'd6, 16'hC006, 7'h00);
    applyStimulus(1'b1, 1'b1, 3'd2, 16'hDEAD, 7'h00);
    #3;
    chk("mid rst in_ready", in_ready, 1'b0);
    chk("mid rst held valid", out_valid, 7'h47);
    tick();
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h2222, 7'h7F);
    #3;
    chk("post rst out_valid", out_valid, 7'h00);
    chk("post rst out_data", out_data, '0);
    chk("post rst in_ready", in_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F);
    #3;
    chk("post rst deliver valid", out_valid, 7'h04);
    chk("post rst deliver data", out_data[2*W +: W], 16'h2222);
    tick();

    // Randomized traffic; upstream holds its word while stalled.
    rs = 3'd0;
    rd = '0;
    rv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(stalled && rv)) begin
        rv = ($urandom_range(3, 0) != 0);
        rs = 3'($urandom_range(7, 0));
        rd = W'($urandom);
      end
      applyStimulus(($urandom_range(49, 0) == 0), rv, rs, rd, 7'($urandom));
      #3;
      checkOutput($sformatf("rand%0d", i));
      tick();
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Saturation of the discard counter.
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 7'h7F);
    tick();
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd7, 16'd42, 7'h7F);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 3'd7, 16'd42, 7'h7F);
    #3;
    chk("drop saturated", drop_count, 16'hFFFF);
    checkOutput("sat");
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 7'h7F);
    #3;
    chk("drop stays saturated", drop_count, 16'hFFFF);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-7 stream demultiplexer with valid/ready handshakes, the routing counterpart of the 7-way select mux. Each input word carries a 3-bit destination code; codes 0–6 deliver the word to one of seven output channels, and code 7 consumes and discards it. Each channel has a one-entry output register, so a stalled channel never blocks traffic bound for the others beyond the word currently addressed to it.

## Interface
- WIDTH, 16, data width of input and every output channel.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  3  destination: 0–6 select a channel, 7 discards the word.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- out_data  output  7*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  7  bit k: channel k holds a word.
- out_ready  input  7  bit k: downstream of channel k accepts this cycle.
- drop_count  output  16  number of discarded words; present only with STREAM_DEMUX_DROP_CNT_EN.

## Operation
- Per channel k: register data_k (WIDTH) and valid_k, driving out_data slice k and out_valid[k].
- in_ready is combinational:
  - 0 while rst is high;
  - 1 when in_sel == 7;
  - otherwise !valid_s || out_ready[s], with s = in_sel.
- Accept = in_valid && in_ready. On accept with s < 7: data_s <= in_data, valid_s <= 1.
- On accept with s == 7: word discarded; no channel changes; drop counter increments if compiled in.
- Channel k drains when valid_k && out_ready[k] and no accept to k in that cycle: valid_k <= 0; data_k holds its last value.
- Drain and load to the same channel in one cycle: valid_k stays 1 and data_k takes the new word, giving one word per cycle per channel.
- Channels are independent. A load to channel j and drains on any other channels occur in the same cycle.
- out_data slices change only on load or reset. Upstream holds in_data/in_sel stable while in_valid && !in_ready.

## Timing
- Reset (rst high at an edge): out_valid = 7'b0, all out_data = 0, drop_count = 0, in_ready = 0 for the whole reset cycle.
- Reset mid-operation: all held words are lost and valid cleared; no handshake completes during reset.
- Latency: a word accepted at edge n appears on out_valid/out_data of its channel after edge n, visible in cycle n+1.
- Throughput: 1 word/cycle when destinations are free or draining.
- Code 7 is always ready, so a discard never stalls.
- Backpressure: with valid_s = 1 and out_ready[s] = 0, in_ready = 0 for sel s only. Changing in_sel while stalled is an upstream protocol violation and is not checked.
- out_ready has a combinational path to in_ready. There is no combinational path from in_data to any output.

## Configuration
- STREAM_DEMUX_DROP_CNT_EN defined:
  - drop_count port and 16-bit register exist;
  - the register increments on every accepted code-7 word;
  - it saturates at 16'hFFFF;
  - reset clears it to 0.
- STREAM_DEMUX_DROP_CNT_EN undefined: no drop_count port and no counter logic; code-7 words are still discarded with in_ready = 1.

## Test plan
- Reset: rst high 2 cycles with in_valid = 1, in_sel = 0 -> in_ready = 0, out_valid = 0, out_data all 0, drop_count = 0.
- Routing: out_ready = 7'h7F, send 16'h1000+k with in_sel = k for k = 0..6 on consecutive cycles -> each channel k asserts out_valid[k] one cycle after its accept with 16'h1000+k, one channel valid per cycle.
- Backpressure:
  - out_ready[3] = 0, send 16'hAAAA then 16'hBBBB to sel 3 -> first accepted; in_ready = 0 for the second; out_data[3] = 16'hAAAA held.
  - Meanwhile a word to sel 5 is accepted.
  - Raising out_ready[3] -> 16'hBBBB accepted in the same cycle the drain occurs, and out_valid[3] stays 1.
- Discard: 10 words with in_sel = 7 and in_data = 16'd42 -> in_ready = 1 every cycle; out_valid unchanged; drop_count = 10 with macro defined.
- Saturation (macro defined): force 65540 discards -> drop_count = 16'hFFFF and stays there.
- Reset mid-stream: channels 0, 2 and 6 holding words with out_ready = 0, assert rst for 1 cycle -> out_valid = 0 and out_data = 0 next cycle; the first post-reset word to sel 2 is delivered normally.
